// File: rtl/adc_burst_sequencer.sv
// Burst acquisition controller for the ADC clock/trigger block: programs the divider,
// waits out a settle window, then captures one sample per trigger edge into a 2-deep FIFO.
module adc_burst_sequencer #(
   parameter int DIV_W  = 14,
   parameter int CNT_W  = 16,
   parameter int DATA_W = 12,
   parameter int SETTLE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DIV_W-1:0]  div_cfg,
   input  logic [CNT_W-1:0]  num_samples,
   output logic              adc_we,
   output logic [DIV_W-1:0]  adc_bn,
   input  logic              adc_trigger,
   input  logic [DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0] smp_data,
   output logic              smp_valid,
   input  logic              smp_ready,
   output logic              busy,
   output logic              done,
   output logic              overrun,
   output logic [CNT_W-1:0]  smp_count
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_SETTLE,
      ST_ACQ,
      ST_DONE
   } state_t;

   state_t              r_state;
   logic [SW-1:0]       r_settleCnt;
   logic [CNT_W-1:0]    r_num;
   logic                r_trigD;

   logic [DATA_W-1:0]   r_mem [2];
   logic                r_wrPtr;
   logic                r_rdPtr;
   logic [1:0]          r_fill;

   logic                w_trigEvent;
   logic                w_capture;
   logic                w_pop;
   logic                w_full;
   logic                w_push;
   logic                w_drop;
   logic [DIV_W-1:0]    w_divSafe;

   // A divider of zero would stall the ADC clock, so it is promoted to one.
   assign w_divSafe   = (div_cfg == '0) ? DIV_W'(1) : div_cfg;
   assign w_trigEvent = adc_trigger & ~r_trigD;
   assign w_capture   = (r_state == ST_ACQ) && !abort && (smp_count != r_num) && w_trigEvent;
   assign smp_valid   = (r_fill != 2'd0);
   assign smp_data    = r_mem[r_rdPtr];
   assign w_full      = (r_fill == 2'd2);
   assign w_pop       = smp_valid && smp_ready;
   assign w_push      = w_capture && (!w_full || w_pop);
   assign w_drop      = w_capture && w_full && !w_pop;

   // When full, a same-cycle pop frees the head slot that the write pointer aliases.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_fill  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= adc_data;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         if (w_push && !w_pop) begin
            r_fill <= r_fill + 2'd1;
         end else if (w_pop && !w_push) begin
            r_fill <= r_fill - 2'd1;
         end
      end
   end

   // Outputs are set on the transition into each state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_settleCnt <= '0;
         r_num       <= '0;
         r_trigD     <= 1'b0;
         adc_we      <= 1'b0;
         adc_bn      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
         smp_count   <= '0;
      end else begin
         r_trigD <= adc_trigger;
         adc_we  <= 1'b0;
         done    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_num     <= num_samples;
                  smp_count <= '0;
                  overrun   <= 1'b0;
                  adc_we    <= 1'b1;
                  adc_bn    <= w_divSafe;
                  busy      <= 1'b1;
                  r_state   <= ST_CFG;
               end
            end
            ST_CFG: begin
               if (abort) begin
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_settleCnt <= SW'(SETTLE - 1);
                  r_state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_settleCnt == '0) begin
                  if (r_num == '0) begin
                     done    <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_ACQ;
                  end
               end else begin
                  r_settleCnt <= r_settleCnt - 1'b1;
               end
            end
            ST_ACQ: begin
               if (abort) begin
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (smp_count == r_num) begin
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_trigEvent) begin
                  if (smp_count != '1) begin
                     smp_count <= smp_count + 1'b1;
                  end
                  if (w_drop) begin
                     overrun <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Self-checking bench for adc_burst_sequencer: a directed vector table, hand-built corner
// sequences and a randomized run, all compared against a cycle-level burst model.
module tb_adc_burst_sequencer;

   localparam int DIV_W  = 14;
   localparam int CNT_W  = 16;
   localparam int DATA_W = 12;
   localparam int SETTLE = 4;

   logic              clk;
   logic              rst;
   logic              start;
   logic              abort;
   logic [DIV_W-1:0]  div_cfg;
   logic [CNT_W-1:0]  num_samples;
   logic              adc_we;
   logic [DIV_W-1:0]  adc_bn;
   logic              adc_trigger;
   logic [DATA_W-1:0] adc_data;
   logic [DATA_W-1:0] smp_data;
   logic              smp_valid;
   logic              smp_ready;
   logic              busy;
   logic              done;
   logic              overrun;
   logic [CNT_W-1:0]  smp_count;

   adc_burst_sequencer #(
      .DIV_W(DIV_W), .CNT_W(CNT_W), .DATA_W(DATA_W), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .div_cfg(div_cfg), .num_samples(num_samples),
      .adc_we(adc_we), .adc_bn(adc_bn),
      .adc_trigger(adc_trigger), .adc_data(adc_data),
      .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
      .busy(busy), .done(done), .overrun(overrun), .smp_count(smp_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit rst, start, abort, trig, ready;
      int div, num, data;
      bit eBusy, eWe, eDone, eValid;
      int eBn, eCount;
   } vec_t;

   int nCompared   = 0;
   int nMismatched = 0;
   int doneSeen    = 0;
   int weSeen      = 0;
   int got[$];

   // Burst model: mAge counts cycles since the start was accepted (1 = divider write,
   // 2..SETTLE+1 = settle window, beyond that = acquiring).
   bit mActive   = 0;
   bit mInDone   = 0;
   int mAge      = 0;
   int mNum      = 0;
   int mCount    = 0;
   bit mOverrun  = 0;
   bit mDone     = 0;
   bit mWe       = 0;
   int mBn       = 0;
   bit mTrigPrev = 0;
   int mQ[$];

   function automatic void modelStep();
      bit ev;
      bit pop;
      if (rst) begin
         mActive = 0; mInDone = 0; mAge = 0; mNum = 0; mCount = 0;
         mOverrun = 0; mDone = 0; mWe = 0; mBn = 0; mTrigPrev = 0;
         mQ.delete();
         return;
      end
      ev = adc_trigger && !mTrigPrev;
      mTrigPrev = adc_trigger;
      pop = (mQ.size() > 0) && smp_ready;
      mDone = 0;
      mWe = 0;
      if (pop) void'(mQ.pop_front());
      if (!mActive) begin
         if (start) begin
            mActive = 1; mAge = 1; mNum = int'(num_samples); mCount = 0;
            mOverrun = 0; mWe = 1;
            mBn = (div_cfg == 0) ? 1 : int'(div_cfg);
         end
      end else if (mInDone) begin
         mActive = 0;
         mInDone = 0;
      end else if (abort) begin
         mActive = 0;
      end else if (mAge <= SETTLE) begin
         mAge++;
      end else if (mAge == SETTLE + 1) begin
         mAge++;
         if (mNum == 0) begin
            mInDone = 1;
            mDone = 1;
         end
      end else if (mCount == mNum) begin
         mInDone = 1;
         mDone = 1;
      end else if (ev) begin
         if (mCount < 65535) mCount++;
         if (mQ.size() < 2) mQ.push_back(int'(adc_data));
         else mOverrun = 1;
      end
   endfunction

   task automatic checkVal(input string nm, input int act, input int exp);
      nCompared++;
      if (act != exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkVal("busy", int'(busy), int'(mActive));
      checkVal("done", int'(done), int'(mDone));
      checkVal("adc_we", int'(adc_we), int'(mWe));
      checkVal("adc_bn", int'(adc_bn), mBn);
      checkVal("smp_valid", int'(smp_valid), (mQ.size() > 0) ? 1 : 0);
      if (mQ.size() > 0) checkVal("smp_data", int'(smp_data), mQ[0]);
      checkVal("overrun", int'(overrun), int'(mOverrun));
      checkVal("smp_count", int'(smp_count), mCount);
      if (done) doneSeen++;
      if (adc_we) weSeen++;
   endtask

   task automatic applyStimulus();
      if (smp_valid && smp_ready) got.push_back(int'(smp_data));
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic pulseTrig(input int d);
      adc_trigger = 1'b1;
      adc_data    = DATA_W'(d);
      applyStimulus();
      adc_trigger = 1'b0;
      applyStimulus();
   endtask

   task automatic startBurst(input int d, input int n);
      div_cfg     = DIV_W'(d);
      num_samples = CNT_W'(n);
      start       = 1'b1;
      applyStimulus();
      start       = 1'b0;
   endtask

   vec_t tbl[10];

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; div_cfg = '0; num_samples = '0;
      adc_trigger = 1'b0; adc_data = '0; smp_ready = 1'b1;

      // Reset with start held, then a zero-length burst with div_cfg=0 and a settle-time trigger.
      tbl[0] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 0,0,0, 1'b0,1'b0,1'b0,1'b0, 0,0};
      tbl[1] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 0,0,0, 1'b0,1'b0,1'b0,1'b0, 0,0};
      tbl[2] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 0,0,0, 1'b0,1'b0,1'b0,1'b0, 0,0};
      tbl[3] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 0,0,0, 1'b1,1'b1,1'b0,1'b0, 1,0};
      tbl[4] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 0,0,0, 1'b1,1'b0,1'b0,1'b0, 1,0};
      tbl[5] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 0,0,5, 1'b1,1'b0,1'b0,1'b0, 1,0};
      tbl[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 0,0,0, 1'b1,1'b0,1'b0,1'b0, 1,0};
      tbl[7] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 0,0,0, 1'b1,1'b0,1'b0,1'b0, 1,0};
      tbl[8] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 0,0,0, 1'b1,1'b0,1'b1,1'b0, 1,0};
      tbl[9] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 0,0,0, 1'b0,1'b0,1'b0,1'b0, 1,0};

      for (int i = 0; i < 10; i++) begin
         rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
         adc_trigger = tbl[i].trig; smp_ready = tbl[i].ready;
         div_cfg = DIV_W'(tbl[i].div); num_samples = CNT_W'(tbl[i].num);
         adc_data = DATA_W'(tbl[i].data);
         applyStimulus();
         checkVal("tbl_busy", int'(busy), int'(tbl[i].eBusy));
         checkVal("tbl_we", int'(adc_we), int'(tbl[i].eWe));
         checkVal("tbl_bn", int'(adc_bn), tbl[i].eBn);
         checkVal("tbl_done", int'(done), int'(tbl[i].eDone));
         checkVal("tbl_valid", int'(smp_valid), int'(tbl[i].eValid));
         checkVal("tbl_count", int'(smp_count), tbl[i].eCount);
      end
      start = 1'b0;
      adc_trigger = 1'b0;

      $display("[TB] normal burst");
      doneSeen = 0; weSeen = 0; got.delete(); smp_ready = 1'b1;
      startBurst(10, 3);
      checkVal("norm_bn", int'(adc_bn), 10);
      idleCycles(8);
      pulseTrig('h123); idleCycles(8);
      pulseTrig('h456); idleCycles(8);
      pulseTrig('h789); idleCycles(4);
      checkVal("norm_we_pulses", weSeen, 1);
      checkVal("norm_done_pulses", doneSeen, 1);
      checkVal("norm_count", int'(smp_count), 3);
      checkVal("norm_overrun", int'(overrun), 0);
      checkVal("norm_nsamples", got.size(), 3);
      if (got.size() == 3) begin
         checkVal("norm_s0", got[0], 'h123);
         checkVal("norm_s1", got[1], 'h456);
         checkVal("norm_s2", got[2], 'h789);
      end

      $display("[TB] backpressure");
      doneSeen = 0; got.delete(); smp_ready = 1'b0;
      startBurst(7, 4);
      idleCycles(8);
      for (int k = 0; k < 4; k++) begin
         pulseTrig('hA01 + k);
         idleCycles(3);
      end
      idleCycles(2);
      checkVal("bp_count", int'(smp_count), 4);
      checkVal("bp_overrun", int'(overrun), 1);
      checkVal("bp_done_pulses", doneSeen, 1);
      smp_ready = 1'b1;
      idleCycles(5);
      checkVal("bp_drained", got.size(), 2);
      if (got.size() == 2) begin
         checkVal("bp_s0", got[0], 'hA01);
         checkVal("bp_s1", got[1], 'hA02);
      end

      $display("[TB] abort mid-acquisition");
      doneSeen = 0; got.delete(); smp_ready = 1'b0;
      startBurst(3, 5);
      idleCycles(8);
      pulseTrig('h5A5);
      idleCycles(2);
      abort = 1'b1;
      adc_trigger = 1'b1;
      adc_data = DATA_W'('hBAD);
      applyStimulus();
      abort = 1'b0;
      adc_trigger = 1'b0;
      checkVal("abort_busy", int'(busy), 0);
      idleCycles(3);
      checkVal("abort_done_pulses", doneSeen, 0);
      checkVal("abort_count", int'(smp_count), 1);
      smp_ready = 1'b1;
      idleCycles(3);
      checkVal("abort_drained", got.size(), 1);
      if (got.size() == 1) checkVal("abort_s0", got[0], 'h5A5);

      $display("[TB] full FIFO with simultaneous pop, start while busy");
      doneSeen = 0; got.delete(); smp_ready = 1'b0;
      startBurst(25, 3);
      idleCycles(2);
      startBurst(77, 9);
      idleCycles(6);
      pulseTrig('h111); idleCycles(2);
      pulseTrig('h222); idleCycles(2);
      adc_trigger = 1'b1;
      adc_data = DATA_W'('h333);
      smp_ready = 1'b1;
      applyStimulus();
      adc_trigger = 1'b0;
      smp_ready = 1'b0;
      idleCycles(4);
      checkVal("full_overrun", int'(overrun), 0);
      checkVal("full_count", int'(smp_count), 3);
      checkVal("full_bn", int'(adc_bn), 25);
      checkVal("full_done_pulses", doneSeen, 1);
      smp_ready = 1'b1;
      idleCycles(5);
      checkVal("full_nsamples", got.size(), 3);
      if (got.size() == 3) begin
         checkVal("full_s0", got[0], 'h111);
         checkVal("full_s1", got[1], 'h222);
         checkVal("full_s2", got[2], 'h333);
      end

      $display("[TB] randomized run");
      for (int c = 0; c < 4000; c++) begin
         rst         = ($urandom_range(0, 499) == 0);
         start       = ($urandom_range(0, 5) == 0);
         abort       = ($urandom_range(0, 29) == 0);
         div_cfg     = ($urandom_range(0, 3) == 0) ? '0 : DIV_W'($urandom);
         num_samples = CNT_W'($urandom_range(0, 5));
         if ($urandom_range(0, 2) == 0) adc_trigger = ~adc_trigger;
         adc_data    = DATA_W'($urandom);
         smp_ready   = 1'($urandom_range(0, 1));
         applyStimulus();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
